// File: rtl/sub_parser_mseq.sv
`timescale 1ns/1ps
// sub_parser_mseq
//   Multi-action container extractor. Accepts one header segment plus
//   NUM_ACT packed parse actions. It then retires one action per cycle and
//   emits 2/4/8-byte containers on a valid/ready stream.
//
//   Optional feature: define SUB_PARSER_BOUNDS_CHK_EN to drop actions whose
//   bytes run past the end of the segment, pulsing err for each one.
//   Without it, out-of-range bytes read as zero and err is tied low.
//
// Ports
//   clk, aresetn            clock, synchronous active-low reset
//   in_valid / in_ready     segment handshake (ready only in IDLE)
//   in_seg                  header bytes, byte 0 = in_seg[7:0]
//   in_acts                 action k at [k*ACT_W +: ACT_W]:
//                           {offset, index, type[1:0]}
//   out_valid / out_ready   container handshake
//   out_val                 container value, LSB-aligned, zero-extended
//   out_type, out_seq       container type (01/10/11) and index
//   out_last                no further live action in this segment
//   seg_done                pulse in the cycle the last slot retires
//   err                     pulse when an out-of-range action is dropped
module sub_parser_mseq #(
    parameter int  SEG_W   = 128,
    parameter int  NUM_ACT = 4,
    parameter int  IDX_W   = 3,
    parameter int  VAL_W   = 64,
    localparam int OFF_W   = $clog2(SEG_W / 8),
    localparam int ACT_W   = OFF_W + IDX_W + 2
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEG_W-1:0]         in_seg,
    input  logic [NUM_ACT*ACT_W-1:0] in_acts,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [VAL_W-1:0]         out_val,
    output logic [1:0]               out_type,
    output logic [IDX_W-1:0]         out_seq,
    output logic                     out_last,
    output logic                     seg_done,
    output logic                     err
);

    localparam int PTR_W = (NUM_ACT > 1) ? $clog2(NUM_ACT) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state, state_nxt;
    logic [SEG_W-1:0]         seg_q;
    logic [NUM_ACT*ACT_W-1:0] acts_q;
    logic [PTR_W-1:0]         ptr, ptr_nxt;

    logic [ACT_W-1:0]         cur_act;
    logic [1:0]               cur_type;
    logic [IDX_W-1:0]         cur_idx;
    logic [OFF_W-1:0]         cur_off;
    logic [NUM_ACT-1:0]       slot_live;
    logic                     cur_last;
    logic                     out_free;
    logic                     load;
    logic                     slot_done;
    logic [SEG_W+63:0]        seg_ext;
    logic [63:0]              win;
    logic [VAL_W-1:0]         cur_val;

`ifdef SUB_PARSER_BOUNDS_CHK_EN
    localparam int SEG_B = SEG_W / 8;

    function automatic logic out_of_range(input logic [ACT_W-1:0] a);
        int unsigned nbytes;
        case (a[1:0])
            2'b01:   nbytes = 2;
            2'b10:   nbytes = 4;
            default: nbytes = 8;
        endcase
        return (int unsigned'(a[ACT_W-1:IDX_W+2]) + nbytes) > int unsigned'(SEG_B);
    endfunction
`endif

    assign in_ready = (state == IDLE);
    assign out_free = !out_valid || out_ready;

    assign cur_act  = acts_q[ptr*ACT_W +: ACT_W];
    assign cur_type = cur_act[1:0];
    assign cur_idx  = cur_act[IDX_W+1:2];
    assign cur_off  = cur_act[ACT_W-1:IDX_W+2];

    // 64 zero bits above the segment make reads past the end return zero.
    assign seg_ext = {64'b0, seg_q};
    assign win     = 64'(seg_ext >> {cur_off, 3'b000});

    always_comb begin
        cur_val = '0;
        case (cur_type)
            2'b01:   cur_val[15:0] = win[15:0];
            2'b10:   cur_val[31:0] = win[31:0];
            2'b11:   cur_val[63:0] = win;
            default: cur_val = '0;
        endcase
    end

    // A slot is live if it will actually produce a container.
    always_comb begin
        slot_live = '0;
        for (int unsigned k = 0; k < NUM_ACT; k++) begin
`ifdef SUB_PARSER_BOUNDS_CHK_EN
            slot_live[k] = (acts_q[k*ACT_W +: 2] != 2'b00) &&
                           !out_of_range(acts_q[k*ACT_W +: ACT_W]);
`else
            slot_live[k] = (acts_q[k*ACT_W +: 2] != 2'b00);
`endif
        end
    end

    always_comb begin
        cur_last = 1'b1;
        for (int unsigned k = 0; k < NUM_ACT; k++) begin
            if (k > 32'(ptr) && slot_live[k]) cur_last = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        load      = 1'b0;
        slot_done = 1'b0;
        seg_done  = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = RUN;
                    ptr_nxt   = '0;
                end
            end
            RUN: begin
                if (cur_type == 2'b00) begin
                    slot_done = 1'b1;
                end
`ifdef SUB_PARSER_BOUNDS_CHK_EN
                else if (out_of_range(cur_act)) begin
                    slot_done = 1'b1;
                    err       = 1'b1;
                end
`endif
                else if (out_free) begin
                    slot_done = 1'b1;
                    load      = 1'b1;
                end
                if (slot_done) begin
                    if (ptr == PTR_W'(NUM_ACT - 1)) begin
                        seg_done  = 1'b1;
                        state_nxt = IDLE;
                        ptr_nxt   = '0;
                    end else begin
                        ptr_nxt = ptr + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state     <= IDLE;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_val   <= '0;
            out_type  <= '0;
            out_seq   <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            // A load while the old container drains replaces it with no bubble.
            if (load) begin
                out_valid <= 1'b1;
                out_val   <= cur_val;
                out_type  <= cur_type;
                out_seq   <= cur_idx;
                out_last  <= cur_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            seg_q  <= in_seg;
            acts_q <= in_acts;
        end
    end

endmodule

// File: doc/sub_parser_mseq.md
# sub_parser_mseq

Parametrised, multi-action successor to the single-action container extractor in the parser pipeline. It accepts one header segment of `SEG_W` bits together with `NUM_ACT` packed parse actions. It then retires the actions one per cycle, extracting 2/4/8-byte containers onto a valid/ready output stream with backpressure. It sits between the segment fetch stage and the PHV container writer, and replaces the one-action-per-cycle, no-backpressure extractor.

## Interface
- `SEG_W`, 128, segment width in bits; multiple of 64, at most 512.
- `NUM_ACT`, 4, parse actions carried per segment.
- `IDX_W`, 3, container index width.
- `VAL_W`, 64, output value width; fixed, must be ≥ 64.
- Derived: `OFF_W = clog2(SEG_W/8)`, `ACT_W = OFF_W + IDX_W + 2`.
- `clk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  segment and actions valid.
- `in_ready`  out  1  block can accept a segment.
- `in_seg`  in  SEG_W  header bytes; byte 0 = `in_seg[7:0]`.
- `in_acts`  in  NUM_ACT*ACT_W  action k at `[k*ACT_W +: ACT_W]`. Fields: `[1:0]` type (00 none, 01 2B, 10 4B, 11 8B), `[IDX_W+1:2]` index, `[ACT_W-1:IDX_W+2]` byte offset.
- `out_valid`  out  1  extracted container valid.
- `out_ready`  in  1  downstream accepts.
- `out_val`  out  VAL_W  container value, LSB-aligned, upper bits zero.
- `out_type`  out  2  container type (01/10/11).
- `out_seq`  out  IDX_W  container index.
- `out_last`  out  1  last emitted container of this segment.
- `seg_done`  out  1  one-cycle pulse when a segment is fully retired.
- `err`  out  1  one-cycle pulse on a dropped out-of-range action (macro only; tied 0 otherwise).

## Operation
- FSM has two states: IDLE and RUN. `in_ready = (state==IDLE)`.
- IDLE, on `in_valid && in_ready`:
  - latch `in_seg` and `in_acts`;
  - set `ptr = 0`;
  - move to RUN.
- RUN handles one slot per cycle at `ptr`, subject to these rules:
  - type 00: skip the slot; `ptr` advances with no output.
  - valid type: needs the output register free, i.e. `!out_valid || out_ready`.
    - If free: load `out_val/out_type/out_seq/out_last`, set `out_valid`, advance `ptr`.
    - If not free: stall; `ptr` holds.
- After the slot at `ptr == NUM_ACT-1` is processed, pulse `seg_done` in the same cycle and return to IDLE.
  - A segment whose actions are all type 00 takes NUM_ACT RUN cycles, then `seg_done`; it emits nothing.
- Extraction: `out_val = seg[off*8 +: W]`, where W = 16/32/64.
  - Bytes past `SEG_W/8` read as zero.
  - `out_val[VAL_W-1:W] = 0`.
- `out_last = 1` iff no slot above `ptr` in the latched segment has a non-00 type.
- `out_*` payload is stable while `out_valid && !out_ready`.
- Reset values: `out_valid=0`, `out_val=0`, `out_type=0`, `out_seq=0`, `out_last=0`, `seg_done=0`, `err=0`, state IDLE, `ptr=0`.
- Reset mid-operation discards the latched segment and any pending output. No `seg_done` is issued for it.

## Timing
- Accept at cycle T. Slot 0 is processed at T+1. The first `out_valid` is visible at T+2, assuming slot 0 is valid and there is no backpressure.
- With `out_ready` held high, the block sustains one container per cycle. A segment occupies NUM_ACT RUN cycles plus 1 IDLE accept cycle.
- `seg_done` is asserted in the cycle the state register changes to IDLE. `in_ready` rises in the following cycle.
- Simultaneous output drain and load: `out_valid` stays 1 and the new payload replaces the old with no bubble.
- `out_ready` low while `out_valid` is 0 has no effect on progress.

## Configuration
- `SUB_PARSER_BOUNDS_CHK_EN` defined:
  - an action with `off + W/8 > SEG_W/8` is not emitted;
  - `err` pulses in the cycle its slot is processed;
  - `ptr` advances;
  - `out_last` treats such slots as type 00.
- Undefined: no check is made; out-of-range bytes are zero-filled and the action is emitted normally; `err` is constant 0.

## Test plan
- Basic extraction: `SEG_W=128`, seg bytes `0x00..0x0F`, actions {2B off 3 idx 1, 4B off 4 idx 2, 8B off 8 idx 5, none}, `out_ready=1`. Required:
  - `0x0403` seq1;
  - `0x07060504` seq2;
  - `0x0F0E0D0C0B0A0908` seq5 with `out_last=1`;
  - `seg_done` at T+4.
- Backpressure: same stimulus with `out_ready` low for 3 cycles after the first `out_valid`. Required: `0x0403` held stable, no loss or duplication, `seg_done` delayed by exactly 3 cycles.
- Empty segment: all actions type 00. Required: no `out_valid`, `seg_done` at T+4, `in_ready` high at T+5.
- Out-of-range 8B at off 12:
  - macro off: `out_val=0x000000000F0E0D0C`;
  - macro on: no output and `err=1` pulse.
- Reset mid-RUN: assert `aresetn=0` after the first container. Required: all outputs 0 next cycle, `in_ready=1` after release, a fresh segment processed correctly.
- Back-to-back segments with `in_valid` held. Required: the second is accepted the cycle after the first's `seg_done`, and ordering is preserved.
